sphere_scan_seq: RTL

Per-pixel sphere scan sequencer. It is the read-side initiator for the 4-entry sphere register file. On each Start it walks Read_index 0..3 and captures the registered Sphere_pos/Sphere_col/curr_index returns. It forwards each sphere to the intersection unit over a valid/ready handshake, collects the in-order hit/distance results, and reports the nearest hit (Hit, Hit_index, Hit_col) back toward the sphere register file and the pixel shader.

---
 rtl/sphere_scan_seq.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/sphere_scan_seq.sv
// rtl/sphere_scan_seq.sv - per-pixel sphere scan sequencer with nearest-hit tracking
// Reads the sphere register file, forwards each sphere downstream and reduces hit results to the nearest.
module sphere_scan_seq #(
   parameter int NUM_SPHERES = 4
) (
   input  logic         Clk,
   input  logic         Reset_n,
   input  logic         Start,
   output logic         Busy,
   output logic [1:0]   Read_index,
   input  logic [191:0] Sphere_pos,
   input  logic [23:0]  Sphere_col,
   input  logic [1:0]   curr_index,
   output logic         Out_valid,
   input  logic         Out_ready,
   output logic [191:0] Out_pos,
   output logic [23:0]  Out_col,
   output logic [1:0]   Out_index,
   input  logic         Res_valid,
   input  logic         Res_hit,
   input  logic [63:0]  Res_dist,
   output logic         Done,
   output logic         Hit,
   output logic [1:0]   Hit_index,
   output logic [23:0]  Hit_col
);

   localparam logic [1:0] LAST_IDX = 2'(NUM_SPHERES - 1);
   localparam logic [2:0] RES_MAX  = 3'(NUM_SPHERES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_SEND,
      S_COLLECT,
      S_DONE
   } state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic [1:0]     r_idx;
   logic [2:0]     r_res_cnt;
   logic [63:0]    r_best_dist;
   logic           r_has_best;
   logic [1:0]     r_best_idx;
   logic [23:0]    r_col_buf [0:3];
   logic [191:0]   r_out_pos;
   logic [23:0]    r_out_col;
   logic [1:0]     r_out_index;
   logic           r_hit;
   logic [1:0]     r_hit_index;
   logic [23:0]    r_hit_col;

   logic           w_accept;
   logic           w_res_take;
   logic           w_better;
   logic [2:0]     w_res_cnt_nxt;
   logic           w_has_best_nxt;
   logic [1:0]     w_best_idx_nxt;

   // Results are reduced in every active state except DONE so early returns are never lost.
   always_comb begin
      w_accept       = (r_state == S_SEND) && Out_ready;
      w_res_take     = Res_valid && (r_res_cnt < RES_MAX) &&
                       ((r_state == S_REQ) || (r_state == S_WAIT) ||
                        (r_state == S_SEND) || (r_state == S_COLLECT));
      w_better       = w_res_take && Res_hit && (!r_has_best || (Res_dist < r_best_dist));
      w_res_cnt_nxt  = w_res_take ? (r_res_cnt + 3'd1) : r_res_cnt;
      w_has_best_nxt = r_has_best || w_better;
      w_best_idx_nxt = w_better ? r_res_cnt[1:0] : r_best_idx;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    if (Start) w_state_nxt = S_REQ;
         S_REQ:     w_state_nxt = S_WAIT;
         S_WAIT:    w_state_nxt = S_SEND;
         S_SEND:    if (w_accept) w_state_nxt = (r_idx == LAST_IDX) ? S_COLLECT : S_REQ;
         S_COLLECT: if (w_res_cnt_nxt == RES_MAX) w_state_nxt = S_DONE;
         S_DONE:    w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         r_state     <= S_IDLE;
         r_idx       <= 2'd0;
         r_res_cnt   <= 3'd0;
         r_best_dist <= '1;
         r_has_best  <= 1'b0;
         r_best_idx  <= 2'd0;
         r_out_pos   <= '0;
         r_out_col   <= '0;
         r_out_index <= 2'd0;
         r_hit       <= 1'b0;
         r_hit_index <= 2'd0;
         r_hit_col   <= '0;
         for (int i = 0; i < 4; i++) r_col_buf[i] <= '0;
      end else begin
         r_state <= w_state_nxt;
         if ((r_state == S_IDLE) && Start) begin
            r_idx       <= 2'd0;
            r_res_cnt   <= 3'd0;
            r_best_dist <= '1;
            r_has_best  <= 1'b0;
            r_best_idx  <= 2'd0;
            r_hit       <= 1'b0;
            r_hit_index <= 2'd0;
            r_hit_col   <= '0;
         end else begin
            if (w_accept) r_idx <= r_idx + 2'd1;
            // Register file data is only valid during WAIT; the returned tag is trusted as-is.
            if (r_state == S_WAIT) begin
               r_out_pos              <= Sphere_pos;
               r_out_col              <= Sphere_col;
               r_out_index            <= curr_index;
               r_col_buf[curr_index]  <= Sphere_col;
            end
            r_res_cnt <= w_res_cnt_nxt;
            if (w_better) begin
               r_best_dist <= Res_dist;
               r_has_best  <= 1'b1;
               r_best_idx  <= r_res_cnt[1:0];
            end
            if ((r_state == S_COLLECT) && (w_state_nxt == S_DONE)) begin
               r_hit       <= w_has_best_nxt;
               r_hit_index <= w_has_best_nxt ? w_best_idx_nxt : 2'd0;
               r_hit_col   <= w_has_best_nxt ? r_col_buf[w_best_idx_nxt] : 24'd0;
            end
         end
      end
   end

   assign Busy       = (r_state != S_IDLE);
   assign Out_valid  = (r_state == S_SEND);
   assign Done       = (r_state == S_DONE);
   assign Read_index = (r_state == S_IDLE) ? 2'd0 : r_idx;
   assign Out_pos    = r_out_pos;
   assign Out_col    = r_out_col;
   assign Out_index  = r_out_index;
   assign Hit        = r_hit;
   assign Hit_index  = r_hit_index;
   assign Hit_col    = r_hit_col;

endmodule
